note_highway: RTL and testbench

NOTE_HIGHWAY -- requirements
Module: note_highway

---
 rtl/note_highway_pkg.sv | 11 +
 rtl/note_judge.sv | 19 +
 rtl/note_highway.sv | 92 +++++++++
 tb/tb_note_highway.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_highway_pkg.sv
// note_highway_pkg: shared game state encoding, lane count, counter widths and lane popcount
package note_highway_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FETCH, DONE} state_t;
  localparam int LANES = 4;
  localparam int SCORE_W = 16;
  localparam int MISS_W = 8;
  function automatic logic [2:0] lane_count(input logic [LANES-1:0] v);
    lane_count = '0;
    for (int i = 0; i < LANES; i++) lane_count = lane_count + 3'(v[i]);
  endfunction
endpackage

// File: rtl/note_judge.sv
// note_judge: key edge detection and hit/miss evaluation against the hit row
module note_judge
  import note_highway_pkg::*;
(
  input  logic             active,
  input  logic             shift,
  input  logic [LANES-1:0] keys,
  input  logic [LANES-1:0] keys_prev,
  input  logic [LANES-1:0] hit_row,
  output logic [LANES-1:0] hit_mask,
  output logic [3:0]       miss_inc
);
  logic [LANES-1:0] press;
  always_comb begin
    press = active ? keys & ~keys_prev : '0;
    hit_mask = press & hit_row;
    miss_inc = 4'(lane_count(press & ~hit_row)) + 4'(shift ? lane_count(hit_row & ~press) : 3'd0);
  end
endmodule

// File: rtl/note_highway.sv
// note_highway: four-lane falling-note rhythm game core
module note_highway
  import note_highway_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int ROWS     = 8,
  parameter int SONG_LEN = 64,
  parameter int MAX_MISS = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LANES-1:0]    rnd,
  input  logic [LANES-1:0]    keys,
  output logic                rng_en,
  output logic [4*ROWS-1:0]   highway,
  output logic [SCORE_W-1:0]  score,
  output logic [MISS_W-1:0]   miss_count,
  output logic                busy,
  output logic                game_over
);
  localparam int BW = $clog2(BEAT_DIV);
  localparam int IW = $clog2(SONG_LEN + 2);
  state_t state;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] rows_inserted;
  logic [LANES-1:0] keys_prev;
  logic [LANES-1:0] hit_row;
  logic [LANES-1:0] hit_mask;
  logic [3:0] miss_inc;
  logic active;
  logic fetch;
  logic beat_end;
  logic song_done;
  logic end_cond;
  logic [MISS_W:0] miss_sum;
  logic [SCORE_W:0] score_sum;
  logic [4*ROWS-1:0] judged;
  logic [4*ROWS-1:0] shifted;
  note_judge u_judge (
    .active    (active),
    .shift     (fetch),
    .keys      (keys),
    .keys_prev (keys_prev),
    .hit_row   (hit_row),
    .hit_mask  (hit_mask),
    .miss_inc  (miss_inc)
  );
  always_comb begin
    active = state == RUN || state == FETCH;
    fetch = state == FETCH;
    beat_end = state == RUN && beat_cnt == BW'(BEAT_DIV - 1);
    hit_row = highway[4*ROWS-1 -: 4];
    song_done = rows_inserted == IW'(SONG_LEN) && highway == '0;
    end_cond = active && (miss_count >= MISS_W'(MAX_MISS) || song_done);
    judged = highway & ~{hit_mask, {4*(ROWS-1){1'b0}}};
    shifted = {judged[4*ROWS-5:0], rows_inserted < IW'(SONG_LEN) ? rnd : 4'b0000};
    miss_sum = (MISS_W+1)'(miss_count) + (MISS_W+1)'(miss_inc);
    score_sum = (SCORE_W+1)'(score) + (SCORE_W+1)'(lane_count(hit_mask));
    rng_en = beat_end;
    busy = active;
    game_over = state == DONE;
  end
  always_ff @(posedge clk) begin
    keys_prev <= keys;
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      rows_inserted <= '0;
      highway <= '0;
      score <= '0;
      miss_count <= '0;
      keys_prev <= '0;
    end else if (!active) begin
      if (start) begin
        state <= RUN;
        beat_cnt <= '0;
        rows_inserted <= '0;
        highway <= '0;
        score <= '0;
        miss_count <= '0;
      end
    end else begin
      state <= end_cond ? DONE : beat_end ? FETCH : RUN;
      beat_cnt <= beat_end ? '0 : fetch ? beat_cnt : beat_cnt + 1'b1;
      highway <= fetch ? shifted : judged;
      if (fetch && rows_inserted < IW'(SONG_LEN)) rows_inserted <= rows_inserted + 1'b1;
      score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      miss_count <= miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
    end
  end
endmodule

// File: tb/tb_note_highway.sv
// tb_note_highway: directed and randomized checks of note_highway against a beat-period reference model
module tb_note_highway;
  localparam int BD = 4;
  localparam int RW = 4;
  localparam int SL = 3;
  localparam int MM = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] rnd = '0;
  logic [3:0] keys = '0;
  logic rng_en;
  logic busy;
  logic game_over;
  logic [4*RW-1:0] highway;
  logic [15:0] score;
  logic [7:0] miss_count;
  int tests = 0;
  int fails = 0;
  int m_mode;
  int m_phase;
  int m_ins;
  int m_score;
  int m_miss;
  logic [3:0] m_row [RW];
  logic [3:0] m_prev;
  note_highway #(.BEAT_DIV(BD), .ROWS(RW), .SONG_LEN(SL), .MAX_MISS(MM)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rnd        (rnd),
    .keys       (keys),
    .rng_en     (rng_en),
    .highway    (highway),
    .score      (score),
    .miss_count (miss_count),
    .busy       (busy),
    .game_over  (game_over)
  );
  always #5 clk = ~clk;
  function automatic logic [4*RW-1:0] m_hw();
    logic [4*RW-1:0] v;
    for (int r = 0; r < RW; r++) v[4*r +: 4] = m_row[r];
    return v;
  endfunction
  task automatic m_clear();
    m_phase = 0;
    m_ins = 0;
    m_score = 0;
    m_miss = 0;
    for (int r = 0; r < RW; r++) m_row[r] = '0;
  endtask
  task automatic model_next();
    logic [3:0] press;
    bit ended;
    int add;
    if (rst) begin
      m_mode = 0;
      m_prev = '0;
      m_clear();
      return;
    end
    press = keys & ~m_prev;
    m_prev = keys;
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1;
        m_clear();
      end
      return;
    end
    ended = m_miss >= MM || (m_ins == SL && m_hw() == '0);
    add = 0;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin
        if (m_row[RW-1][i]) begin
          m_row[RW-1][i] = 1'b0;
          if (m_score < 65535) m_score++;
        end else add++;
      end
    end
    if (m_phase == BD) begin
      for (int i = 0; i < 4; i++) add += int'(m_row[RW-1][i]);
      for (int r = RW - 1; r > 0; r--) m_row[r] = m_row[r-1];
      m_row[0] = m_ins < SL ? rnd : 4'b0000;
      if (m_ins < SL) m_ins++;
      m_phase = 0;
    end else m_phase++;
    m_miss = m_miss + add > 255 ? 255 : m_miss + add;
    if (ended) m_mode = 2;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    check("highway", highway, m_hw());
    check("score", score, 64'(m_score));
    check("miss_count", miss_count, 64'(m_miss));
    check("rng_en", rng_en, 64'(m_mode == 1 && m_phase == BD - 1));
    check("busy", busy, 64'(m_mode == 1));
    check("game_over", game_over, 64'(m_mode == 2));
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    keys = '0;
    tick();
    rst = 1'b0;
    check("rst_rng_en", rng_en, 0);
    check("rst_busy", busy, 0);
    check("rst_game_over", game_over, 0);
    check("rst_highway", highway, 0);
  endtask
  initial begin
    int n;
    int bits;
    int ins;
    do_reset();
    rnd = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!rng_en && n < 20) begin
      tick();
      n++;
    end
    check("spawn_cycle", 64'(n), 4);
    tick();
    check("fetch_rng_low", rng_en, 0);
    check("fetch_row0_pre", highway[3:0], 0);
    tick();
    check("spawn_row0", highway[3:0], 4'b1010);
    do_reset();
    rnd = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(20);
    check("hit_row_pre", highway[4*RW-1 -: 4], 4'b0001);
    keys = 4'b0001;
    tick();
    keys = '0;
    check("hit_score", score, 1);
    check("hit_row_clear", highway[4*RW-1 -: 4], 0);
    check("hit_miss", miss_count, 0);
    do_reset();
    rnd = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(20);
    check("drop_row_pre", highway[4*RW-1 -: 4], 4'b1111);
    check("drop_miss_pre", miss_count, 0);
    run(5);
    check("drop_miss", miss_count, 4);
    check("drop_not_over", game_over, 0);
    tick();
    check("drop_over", game_over, 1);
    do_reset();
    rnd = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(24);
    check("coin_fetch_busy", busy, 1);
    check("coin_row_pre", highway[4*RW-1 -: 4], 4'b0011);
    keys = 4'b0001;
    tick();
    keys = '0;
    check("coin_score", score, 1);
    check("coin_miss", miss_count, 1);
    check("coin_new_hit", highway[4*RW-1 -: 4], 4'b0011);
    do_reset();
    bits = 0;
    ins = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !game_over; c++) begin
      keys = keys == '0 ? highway[4*RW-1 -: 4] : 4'b0000;
      if (rng_en) begin
        rnd = 4'($urandom_range(1, 15));
        if (ins < SL) bits += $countones(rnd);
        ins++;
      end
      tick();
    end
    keys = '0;
    check("song_over", game_over, 1);
    check("song_score", score, 64'(bits));
    check("song_miss", miss_count, 0);
    do_reset();
    rnd = 4'($urandom_range(1, 15));
    start = 1'b1;
    tick();
    start = 1'b0;
    run(14);
    check("mid_fetch_busy", busy, 1);
    check("mid_fetch_rng", rng_en, 0);
    check("mid_highway_set", 64'(highway != '0), 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("mid_highway", highway, 0);
    check("mid_score", score, 0);
    check("mid_rng_en", rng_en, 0);
    check("mid_busy", busy, 0);
    tick();
    check("mid_idle_busy", busy, 0);
    check("mid_idle_over", game_over, 0);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 199) == 0;
      start = $urandom_range(0, 19) == 0;
      keys = 4'($urandom);
      rnd = 4'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
